// File: rtl/nv_memory_arbiter_if.sv
// Signal bundle between the nv_memory arbiter and its environment: two requester
// ports, the zeroization control and the nv_memory connection.
interface nv_memory_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  ack0;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  zeroize;
   logic                  zero_busy;
   logic                  zero_done;
   logic                  mem_w;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Environment side: requesters plus the memory itself.
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, zeroize, mem_rdata,
      input  ack0, ack1, rd_data, zero_busy, zero_done, mem_w, mem_addr, mem_wdata
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, zeroize, mem_rdata,
      output ack0, ack1, rd_data, zero_busy, zero_done, mem_w, mem_addr, mem_wdata
   );
endinterface

// File: rtl/nv_memory_arbiter.sv
// Round-robin arbiter for the single-port nv_memory with a full-memory zeroization
// sequence that takes priority over both requesters.
module nv_memory_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   nv_memory_arbiter_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_CAP, ZERO} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   state_t                state;
   logic                  zero_pending;
   logic                  last_grant;
   logic                  cur_port;
   logic                  grant;
   logic                  grant_we;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic [DATA_WIDTH-1:0] grant_wdata;

   // Lone requester wins outright; under contention the port not served last wins.
   assign grant       = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
   assign grant_we    = grant ? bus.we1    : bus.we0;
   assign grant_addr  = grant ? bus.addr1  : bus.addr0;
   assign grant_wdata = grant ? bus.wdata1 : bus.wdata0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         zero_pending  <= 1'b0;
         last_grant    <= 1'b1;
         cur_port      <= 1'b0;
         bus.mem_w     <= 1'b0;
         bus.mem_addr  <= ADDR_ZERO;
         bus.mem_wdata <= DATA_ZERO;
         bus.ack0      <= 1'b0;
         bus.ack1      <= 1'b0;
         bus.rd_data   <= DATA_ZERO;
         bus.zero_busy <= 1'b0;
         bus.zero_done <= 1'b0;
      end else begin
         bus.ack0      <= 1'b0;
         bus.ack1      <= 1'b0;
         bus.zero_done <= 1'b0;
         if (bus.zeroize && state != ZERO) zero_pending <= 1'b1;

         case (state)
            IDLE: begin
               if (zero_pending) begin
                  // Entry clears the pending flag even if zeroize is high again now.
                  zero_pending  <= 1'b0;
                  bus.mem_w     <= 1'b1;
                  bus.mem_addr  <= ADDR_ZERO;
                  bus.mem_wdata <= DATA_ZERO;
                  bus.zero_busy <= 1'b1;
                  state         <= ZERO;
               end else if (bus.req0 || bus.req1) begin
                  last_grant   <= grant;
                  cur_port     <= grant;
                  bus.mem_addr <= grant_addr;
                  if (grant_we) begin
                     bus.mem_w     <= 1'b1;
                     bus.mem_wdata <= grant_wdata;
                     state         <= WRITE;
                  end else begin
                     bus.mem_w <= 1'b0;
                     state     <= RD_ISSUE;
                  end
               end
            end
            WRITE: begin
               bus.mem_w <= 1'b0;
               bus.ack0  <= ~cur_port;
               bus.ack1  <= cur_port;
               state     <= IDLE;
            end
            RD_ISSUE: begin
               state <= RD_CAP;
            end
            RD_CAP: begin
               bus.rd_data <= bus.mem_rdata;
               bus.ack0    <= ~cur_port;
               bus.ack1    <= cur_port;
               state       <= IDLE;
            end
            ZERO: begin
               bus.mem_addr <= bus.mem_addr + ADDR_ONE;
               if (bus.mem_addr == LAST_ADDR) begin
                  bus.mem_w     <= 1'b0;
                  bus.zero_busy <= 1'b0;
                  bus.zero_done <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nv_memory_arbiter.sv
// Bench for nv_memory_arbiter: behavioural nv_memory, per-port expectation queues and
// a memory-content reference model retired by a monitor on every ack / zero_done.
module tb_nv_memory_arbiter;
   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   nv_memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   nv_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Single-port memory with registered read data.
   logic [DW-1:0] mem [DEPTH] = '{default: '0};
   always @(posedge clk) begin
      if (bus.mem_w) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
   txn_t q0[$];
   txn_t q1[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   zd_cnt   = 0;
   int   busy_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.data = d;
      if (p == 0) q0.push_back(t);
      else        q1.push_back(t);
   endtask

   task automatic drive(input int p, input bit r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      if (p == 0) begin
         bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end else begin
         bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end
   endtask

   task automatic retire(input int p);
      txn_t t;
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
         check($sformatf("spurious_ack%0d", p), 1, 0);
         return;
      end
      if (p == 0) t = q0.pop_front();
      else        t = q1.pop_front();
      if (t.we) ref_mem[t.addr] = t.data;
      else check($sformatf("rd_data_p%0d_a%02h", p, t.addr), bus.rd_data, ref_mem[t.addr]);
   endtask

   // Monitor: retires completed transactions and zeroizations against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (bus.zero_busy) busy_cnt++;
         if (bus.ack0 || bus.ack1) check("ack_exclusive", {63'd0, bus.ack0 & bus.ack1}, 0);
         if (bus.ack0) retire(0);
         if (bus.ack1) retire(1);
         if (bus.zero_done) begin
            zd_cnt++;
            check("zero_busy_cycles", busy_cnt, DEPTH);
            busy_cnt = 0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         end
      end
   end

   task automatic wait_ack(input int p, input int budget, output bit got, output int lat);
      got = 1'b0;
      lat = 0;
      while (!got && lat < budget) begin
         @(posedge clk); #1;
         lat++;
         got = (p == 0) ? bus.ack0 : bus.ack1;
      end
   endtask

   // One transaction from an idle arbiter; exp_lat counts edges from request to ack.
   task automatic do_txn(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int exp_lat, output logic [DW-1:0] rd);
      bit got;
      int lat;
      push(p, we, a, d);
      drive(p, 1'b1, we, a, d);
      wait_ack(p, 600, got, lat);
      drive(p, 1'b0, 1'b0, '0, '0);
      if (!got) check($sformatf("ack_timeout_p%0d", p), 0, 1);
      else if (exp_lat > 0) check($sformatf("latency_p%0d_we%0d", p, we), lat, exp_lat);
      rd = bus.rd_data;
   endtask

   task automatic rand_port(input int p, input int n);
      bit            we;
      bit            got;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            lat;
      int            gap;
      for (int t = 0; t < n; t++) begin
         we = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, 15));
         d  = $urandom;
         push(p, we, a, d);
         drive(p, 1'b1, we, a, d);
         wait_ack(p, 600, got, lat);
         if (!got) begin
            check($sformatf("rand_ack_timeout_p%0d", p), 0, 1);
            drive(p, 1'b0, 1'b0, '0, '0);
            return;
         end
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            drive(p, 1'b0, 1'b0, '0, '0);
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      drive(p, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [DW-1:0] rd;
      int            order[$];
      int            n0;
      int            n1;
      int            k;
      int            zd_before;
      int            first;
      bit            got;
      bit            seen_done;
      int            lat;

      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      bus.zeroize = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_w", bus.mem_w, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_ack0", bus.ack0, 0);
      check("rst_ack1", bus.ack1, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_zero_busy", bus.zero_busy, 0);
      check("rst_zero_done", bus.zero_done, 0);

      // Contention from reset: both ports write twice, grants must alternate from port 0.
      push(0, 1'b1, 8'h01, 32'h11); push(0, 1'b1, 8'h01, 32'h11);
      push(1, 1'b1, 8'h02, 32'h22); push(1, 1'b1, 8'h02, 32'h22);
      drive(0, 1'b1, 1'b1, 8'h01, 32'h11);
      drive(1, 1'b1, 1'b1, 8'h02, 32'h22);
      @(negedge clk) rst_n = 1'b1;
      n0 = 0; n1 = 0;
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
         @(posedge clk); #1;
         if (bus.ack0) begin order.push_back(0); n0++; if (n0 == 2) bus.req0 = 1'b0; end
         if (bus.ack1) begin order.push_back(1); n1++; if (n1 == 2) bus.req1 = 1'b0; end
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      check("contention_ack_count", order.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("contention_grant_%0d", i), (i < order.size()) ? order[i] : 9, i % 2);
      do_txn(0, 1'b0, 8'h01, '0, 3, rd);
      check("readback_01", rd, 32'h11);
      do_txn(1, 1'b0, 8'h02, '0, 3, rd);
      check("readback_02", rd, 32'h22);

      // Single-port write then read.
      do_txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 2, rd);
      do_txn(0, 1'b0, 8'h10, '0, 3, rd);
      check("read_10", rd, 32'hDEADBEEF);

      // Fill, zeroize, read back zeros.
      for (int i = 0; i < 4; i++) do_txn(0, 1'b1, AW'(i), 32'hA5A5A5A5, 2, rd);
      zd_before = zd_cnt;
      bus.zeroize = 1'b1;
      @(posedge clk); #1;
      bus.zeroize = 1'b0;
      check("zero_busy_at_z0", bus.zero_busy, 0);
      @(posedge clk); #1;
      check("zero_busy_at_z1", bus.zero_busy, 1);
      check("mem_w_at_z1", bus.mem_w, 1);
      check("mem_addr_at_z1", bus.mem_addr, 0);
      k = 0;
      while (!bus.zero_done && k < 400) begin @(posedge clk); #1; k++; end
      check("zero_done_seen", bus.zero_done, 1);
      repeat (3) @(posedge clk);
      #1;
      check("zero_done_pulses", zd_cnt - zd_before, 1);
      do_txn(1, 1'b0, 8'h00, '0, 3, rd); check("zero_rd_00", rd, 0);
      do_txn(1, 1'b0, 8'h03, '0, 3, rd); check("zero_rd_03", rd, 0);
      do_txn(1, 1'b0, 8'hFF, '0, 3, rd); check("zero_rd_ff", rd, 0);

      // Zeroize arriving during a read: the read completes first.
      do_txn(1, 1'b1, 8'h05, 32'h1234, 2, rd);
      push(1, 1'b0, 8'h05, '0);
      drive(1, 1'b1, 1'b0, 8'h05, '0);
      @(posedge clk); #1;
      bus.zeroize = 1'b1;
      @(posedge clk); #1;
      bus.zeroize = 1'b0;
      wait_ack(1, 10, got, lat);
      drive(1, 1'b0, 1'b0, '0, '0);
      check("zrd_ack1", got, 1);
      check("zrd_rd_data", bus.rd_data, 32'h1234);
      check("zrd_busy_at_ack", bus.zero_busy, 0);
      k = 0;
      while (!bus.zero_busy && k < 5) begin @(posedge clk); #1; k++; end
      check("zrd_busy_rises", bus.zero_busy, 1);
      push(0, 1'b1, 8'h07, 32'hCAFE0007);
      drive(0, 1'b1, 1'b1, 8'h07, 32'hCAFE0007);
      seen_done = 1'b0;
      got = 1'b0;
      k = 0;
      while (!got && k < 400) begin
         @(posedge clk); #1; k++;
         if (bus.zero_done) seen_done = 1'b1;
         got = bus.ack0;
      end
      drive(0, 1'b0, 1'b0, '0, '0);
      check("req_during_zero_acked", got, 1);
      check("ack0_after_zero_done", seen_done, 1);

      // Reset in the middle of zeroization.
      bus.zeroize = 1'b1;
      @(posedge clk); #1;
      bus.zeroize = 1'b0;
      k = 0;
      while (!(bus.zero_busy && bus.mem_addr == 8'h40) && k < 300) begin @(posedge clk); #1; k++; end
      check("reached_addr_40", bus.mem_addr, 8'h40);
      zd_before = zd_cnt;
      rst_n = 1'b0;
      #1;
      check("midrst_mem_w", bus.mem_w, 0);
      check("midrst_zero_busy", bus.zero_busy, 0);
      check("midrst_ack", {bus.ack0, bus.ack1}, 0);
      check("midrst_mem_addr", bus.mem_addr, 0);
      for (int i = 0; i < 'h40; i++) ref_mem[i] = '0;
      push(0, 1'b1, 8'h20, 32'h0BAD0020);
      push(1, 1'b1, 8'h21, 32'h0BAD0021);
      drive(0, 1'b1, 1'b1, 8'h20, 32'h0BAD0020);
      drive(1, 1'b1, 1'b1, 8'h21, 32'h0BAD0021);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      first = 9;
      k = 0;
      while (first == 9 && k < 10) begin
         @(posedge clk); #1; k++;
         if (bus.ack0) first = 0;
         else if (bus.ack1) first = 1;
      end
      check("post_reset_first_grant", first, 0);
      if (first == 1) begin
         drive(1, 1'b0, 1'b0, '0, '0);
         wait_ack(0, 10, got, lat);
         drive(0, 1'b0, 1'b0, '0, '0);
      end else begin
         drive(0, 1'b0, 1'b0, '0, '0);
         wait_ack(1, 10, got, lat);
         drive(1, 1'b0, 1'b0, '0, '0);
      end
      check("post_reset_second_ack", got, 1);
      repeat (5) @(posedge clk);
      #1;
      check("no_zero_done_after_reset", zd_cnt - zd_before, 0);
      do_txn(0, 1'b0, 8'h07, '0, 3, rd);
      check("partial_zero_rd_07", rd, 0);

      // Randomized traffic from both ports with occasional zeroize pulses.
      fork
         rand_port(0, 40);
         rand_port(1, 40);
         begin
            repeat (2) begin
               repeat ($urandom_range(60, 160)) @(posedge clk);
               #1;
               bus.zeroize = 1'b1;
               @(posedge clk); #1;
               bus.zeroize = 1'b0;
            end
         end
      join
      repeat (5) @(posedge clk);
      #1;
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/nv_memory_arbiter.md
# nv_memory_arbiter

Shares the single-port nv_memory (write-or-read per cycle, registered read data) between two requesters with round-robin arbitration. Typical requesters are the bitstream loader and the key manager. Also runs a zeroization sequence that writes 0 to every word on command; zeroization takes priority over both requesters. Sits directly in front of nv_memory and owns all of its address, data and write-enable inputs.

## Interface

Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 8, memory address width; depth = 2^ADDR_WIDTH

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request level, port 0 / 1
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- ack0 / ack1  out  1  one-cycle completion pulse, port 0 / 1
- rd_data  out  DATA_WIDTH  read data; valid in the cycle ack0 or ack1 is high after a read
- zeroize  in  1  one-cycle pulse; start full-memory clear
- zero_busy  out  1  high while zeroization is running
- zero_done  out  1  one-cycle pulse when zeroization completes
- mem_w  out  1  to nv_memory mem_w
- mem_addr  out  ADDR_WIDTH  to nv_memory mem_addr_in
- mem_wdata  out  DATA_WIDTH  to nv_memory mem_data_in
- mem_rdata  in  DATA_WIDTH  from nv_memory mem_data_out

## Operation

- All outputs are registered.
- Reset values: state IDLE, mem_w 0, mem_addr 0, mem_wdata 0, ack0/ack1 0, rd_data 0, zero_busy 0, zero_done 0, zero_pending 0, last_grant 1 (port 0 wins the first contention).
- States: IDLE, WRITE, RD_ISSUE, RD_CAP, ZERO.
- zero_pending:
  - Set at any edge where zeroize is high and state is not ZERO.
  - Cleared on entry to ZERO.
  - zeroize during ZERO is ignored.
- IDLE, priority order:
  - zero_pending: go to ZERO; mem_w<=1, mem_addr<=0, mem_wdata<=0, zero_busy<=1.
  - Else one req high: grant that port.
  - Else both req high: grant the port that is not last_grant.
  - On grant: last_grant<=port; mem_addr<=addrN. If weN, mem_w<=1, mem_wdata<=wdataN, go to WRITE; else mem_w<=0, go to RD_ISSUE.
- WRITE: memory performs the write at this edge. mem_w<=0, ackN<=1, go to IDLE.
- RD_ISSUE: memory registers the word at this edge; mem_addr held. Go to RD_CAP.
- RD_CAP: rd_data<=mem_rdata, ackN<=1, go to IDLE.
- ZERO:
  - Each edge, memory writes 0 at mem_addr and mem_addr increments.
  - At the edge where mem_addr = 2^ADDR_WIDTH-1: mem_w<=0, zero_busy<=0, zero_done<=1, go to IDLE. mem_addr wraps to 0.
- ack0, ack1 and zero_done are high for exactly one cycle. ack0 and ack1 are never high together.
- rd_data holds its value until the next read completes; writes do not change it.
- Requester rule:
  - Hold req, we, addr and wdata stable until ack.
  - req high at the edge that ends the ack cycle is a new transaction (back-to-back allowed).
- mem_w is 0 whenever the arbiter is not writing. nv_memory then performs a harmless read.

## Timing

- Write: accepted at edge E0 → memory written at E1 → ack high E1..E2. Sustained rate: 1 write per 2 cycles per winning port.
- Read: accepted at E0 → mem_rdata valid after E1 → rd_data and ack high E2..E3. Sustained rate: 1 read per 3 cycles.
- Zeroize:
  - Pulse sampled at edge Z0 while in IDLE → ZERO entered at Z1 with mem_w high.
  - 2^ADDR_WIDTH write cycles follow.
  - zero_done high for one cycle after edge Z1+2^ADDR_WIDTH.
  - zero_busy is high from Z1 until that same edge.
- Zeroize during a transaction: the transaction completes normally, then ZERO starts at the next IDLE edge.
- Requests arriving during ZERO wait; no ack until zeroization ends.
- rst_n low, any state: all outputs go to reset values immediately (asynchronously), including mem_w 0. An in-flight transaction or zeroization is dropped with no ack and no zero_done.

## Test plan

- Port 0 writes 0xDEADBEEF to addr 0x10, then reads addr 0x10: ack0 one cycle after the write acceptance edge; rd_data = 0xDEADBEEF with ack0 two cycles after the read acceptance edge; ack1 never asserts.
- req0 and req1 held high from reset, both writing (port 0: 0x11 to addr 0x01, port 1: 0x22 to addr 0x02): grants alternate 0,1,0,1; ack pulses alternate; reading back gives 0x11 and 0x22.
- Fill addrs 0..3 with 0xA5A5A5A5, pulse zeroize: zero_busy high for exactly 256 cycles, one zero_done pulse; reads of addrs 0, 3 and 255 return 0.
- zeroize pulsed during a port 1 read of 0x1234 at addr 5: ack1 with rd_data = 0x1234 first, then zero_busy rises; a req0 raised during ZERO is acked only after zero_done.
- rst_n asserted mid-ZERO at mem_addr 0x40: mem_w, zero_busy and ack drop immediately; zero_done never pulses; after release, port 0 wins the first contended grant.
